// File: rtl/isqrt_seq.sv
// Iterative digit-pair integer square root with valid/ready handshakes on both sides.
// Resolves STEPS root bits per clock and can return a floor or a round-to-nearest root.
module isqrt_seq #(
    parameter int WIDTH = 16,
    parameter int STEPS = 1,
    localparam int RW   = WIDTH / 2,
    localparam int NCYC = RW / STEPS,
    localparam int CW   = $clog2(NCYC + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic          in_round,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW:0]   root_o,
    output logic [RW:0]   rem_o,
    output logic          exact_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] rad;
    logic [RW-1:0]    q;
    logic [RW+1:0]    r;
    logic [CW-1:0]    cnt;
    logic             round_mode;

    logic [WIDTH-1:0] rad_nx;
    logic [RW-1:0]    q_nx;
    logic [RW+1:0]    r_nx;
    logic [RW+1:0]    r_sh;
    logic [RW+1:0]    trial;
    logic [RW:0]      root_rnd;

    // STEPS chained digit-pair iterations, consuming the radicand MSB pair first.
    always_comb begin
        rad_nx = rad;
        q_nx   = q;
        r_nx   = r;
        r_sh   = '0;
        trial  = '0;
        for (int i = 0; i < STEPS; i++) begin
            r_sh  = {r_nx[RW-1:0], rad_nx[WIDTH-1 -: 2]};
            trial = {q_nx, 2'b01};
            if (r_sh >= trial) begin
                r_nx = r_sh - trial;
                q_nx = {q_nx[RW-2:0], 1'b1};
            end else begin
                r_nx = r_sh;
                q_nx = {q_nx[RW-2:0], 1'b0};
            end
            rad_nx = {rad_nx[WIDTH-3:0], 2'b00};
        end
    end

    // R > Q is the same test as x > Q^2 + Q, so no tie case exists.
    assign root_rnd = {1'b0, q} + {{RW{1'b0}}, (r > {2'b00, q})};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rad        <= '0;
            q          <= '0;
            r          <= '0;
            cnt        <= '0;
            round_mode <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            root_o     <= '0;
            rem_o      <= '0;
            exact_o    <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        rad        <= in_data;
                        round_mode <= in_round;
                        q          <= '0;
                        r          <= '0;
                        cnt        <= '0;
                        in_ready   <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    rad <= rad_nx;
                    q   <= q_nx;
                    r   <= r_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(NCYC - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle registers the result; later cycles wait for the consumer.
                    if (!out_valid) begin
                        root_o    <= round_mode ? root_rnd : {1'b0, q};
                        rem_o     <= r[RW:0];
                        exact_o   <= (r == '0);
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_seq.sv
// Bench for isqrt_seq: directed WIDTH=16/STEPS=1 cases plus a randomized WIDTH=32/STEPS=2 sweep,
// all checked against an arithmetic square-root model.
module tb_isqrt_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        iv16 = 1'b0, ir16, rnd16 = 1'b0, ov16, ordy16 = 1'b0, ex16, busy16;
    logic [15:0] id16 = '0;
    logic [8:0]  root16, rem16;

    logic        iv32 = 1'b0, ir32, rnd32 = 1'b0, ov32, ordy32 = 1'b0, ex32, busy32;
    logic [31:0] id32 = '0;
    logic [16:0] root32, rem32;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit     pend16 = 0, pend32 = 0, ovp16 = 0, ovp32 = 0;
    int     acc16 = 0, acc32 = 0;
    longint er16, em16, er32, em32;

    always #5 clk = ~clk;

    isqrt_seq #(.WIDTH(16), .STEPS(1)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_data(id16),
        .in_round(rnd16), .out_valid(ov16), .out_ready(ordy16), .root_o(root16),
        .rem_o(rem16), .exact_o(ex16), .busy_o(busy16)
    );

    isqrt_seq #(.WIDTH(32), .STEPS(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_data(id32),
        .in_round(rnd32), .out_valid(ov32), .out_ready(ordy32), .root_o(root32),
        .rem_o(rem32), .exact_o(ex32), .busy_o(busy32)
    );

    // Reference model: floor root from real sqrt, nudged to the exact integer answer.
    function automatic longint fsqrt(longint x);
        longint s;
        s = longint'($sqrt(real'(x)));
        while (s * s > x) s--;
        while ((s + 1) * (s + 1) <= x) s++;
        return s;
    endfunction

    // Nearest integer to sqrt(x): round up when x > (f + 1/2)^2, i.e. 4x > (2f+1)^2.
    function automatic longint exp_root(longint x, bit rnd);
        longint f;
        f = fsqrt(x);
        if (rnd && (4 * x > (2 * f + 1) * (2 * f + 1))) return f + 1;
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accept/deliver tracking; reads pre-edge values of the DUT registers.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            pend16 = 0;
            pend32 = 0;
        end else begin
            if (ov16 && ordy16) pend16 = 0;
            if (iv16 && ir16) begin
                pend16 = 1;
                acc16  = cyc;
                er16   = exp_root(longint'(id16), rnd16);
                em16   = longint'(id16) - fsqrt(longint'(id16)) ** 2;
            end
            if (ov32 && ordy32) pend32 = 0;
            if (iv32 && ir32) begin
                pend32 = 1;
                acc32  = cyc;
                er32   = exp_root(longint'(id32), rnd32);
                em32   = longint'(id32) - fsqrt(longint'(id32)) ** 2;
            end
        end
    end

    // Single compare process: every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (rst) begin
            ovp16 = 0;
            ovp32 = 0;
        end else begin
            if (ov16) begin
                if (!pend16) checkOutput("ov16_without_op", ov16, 1'b0);
                else begin
                    checkOutput("root16", root16, er16);
                    checkOutput("rem16", rem16, em16);
                    checkOutput("exact16", ex16, em16 == 0);
                    checkOutput("in_ready16_in_done", ir16, 1'b0);
                    checkOutput("busy16_in_done", busy16, 1'b1);
                    if (!ovp16) checkOutput("latency16", cyc - acc16, 9);
                end
            end
            if (ov32) begin
                if (!pend32) checkOutput("ov32_without_op", ov32, 1'b0);
                else begin
                    checkOutput("root32", root32, er32);
                    checkOutput("rem32", rem32, em32);
                    checkOutput("exact32", ex32, em32 == 0);
                    checkOutput("in_ready32_in_done", ir32, 1'b0);
                    if (!ovp32) checkOutput("latency32", cyc - acc32, 9);
                end
            end
            ovp16 = ov16;
            ovp32 = ov32;
        end
    end

    task automatic startOp16(input logic [15:0] x, input logic r);
        int k = 0;
        @(negedge clk);
        while (!ir16 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ir16) checkOutput("in_ready16_timeout", ir16, 1'b1);
        iv16  = 1'b1;
        id16  = x;
        rnd16 = r;
        @(negedge clk);
        iv16  = 1'b0;
        id16  = 16'($urandom);
        rnd16 = 1'($urandom);
    endtask

    task automatic applyStimulus16(input logic [15:0] x, input logic r);
        int k = 0;
        startOp16(x, r);
        while (!ov16 && k < 40) begin
            iv16 = 1'($urandom);
            @(negedge clk);
            k++;
        end
        iv16 = 1'b0;
        if (!ov16) checkOutput("out_valid16_timeout", ov16, 1'b1);
    endtask

    task automatic finishOp16();
        ordy16 = 1'b1;
        @(negedge clk);
        ordy16 = 1'b0;
        checkOutput("ov16_dropped", ov16, 1'b0);
    endtask

    task automatic runOp32(input logic [31:0] x, input logic r);
        int k = 0;
        while (!ir32 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ir32) checkOutput("in_ready32_timeout", ir32, 1'b1);
        iv32  = 1'b1;
        id32  = x;
        rnd32 = r;
        @(negedge clk);
        k = 0;
        while (!ov32 && k < 40) begin
            iv32   = 1'($urandom);
            id32   = $urandom;
            ordy32 = 1'($urandom);
            @(negedge clk);
            k++;
        end
        iv32 = 1'b0;
        if (!ov32) checkOutput("out_valid32_timeout", ov32, 1'b1);
        k = 0;
        while (ov32 && k < 100) begin
            ordy32 = 1'($urandom);
            @(negedge clk);
            k++;
        end
        ordy32 = 1'b0;
        if (ov32) checkOutput("handshake32_timeout", ov32, 1'b0);
    endtask

    initial begin
        // Hand-computed pins on the model itself.
        checkOutput("model_floor_65535", fsqrt(65535), 255);
        checkOutput("model_round_65535", exp_root(65535, 1), 256);
        checkOutput("model_round_210", exp_root(210, 1), 14);
        checkOutput("model_round_211", exp_root(211, 1), 15);
        checkOutput("model_round_max32", exp_root(64'hFFFF_FFFF, 1), 65536);
        checkOutput("model_floor_max32", fsqrt(64'hFFFF_FFFF), 65535);

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", ir16, 1'b1);
        checkOutput("rst_out_valid", ov16, 1'b0);
        checkOutput("rst_root", root16, 0);
        checkOutput("rst_rem", rem16, 0);
        checkOutput("rst_exact", ex16, 1'b0);
        checkOutput("rst_busy", busy16, 1'b0);
        rst = 1'b0;
        #1 checkOutput("post_rst_in_ready", ir16, 1'b1);

        applyStimulus16(16'd0, 1'b0);
        checkOutput("x0_root", root16, 0);
        checkOutput("x0_exact", ex16, 1'b1);
        finishOp16();

        applyStimulus16(16'd65535, 1'b0);
        checkOutput("x65535_floor_root", root16, 255);
        checkOutput("x65535_floor_rem", rem16, 510);
        checkOutput("x65535_exact", ex16, 1'b0);
        finishOp16();
        applyStimulus16(16'd65535, 1'b1);
        checkOutput("x65535_round_root", root16, 256);
        checkOutput("x65535_round_rem", rem16, 510);
        finishOp16();

        applyStimulus16(16'd210, 1'b0);
        checkOutput("x210_floor", root16, 14);
        checkOutput("x210_rem", rem16, 14);
        finishOp16();
        applyStimulus16(16'd210, 1'b1);
        checkOutput("x210_round", root16, 14);
        finishOp16();
        applyStimulus16(16'd211, 1'b1);
        checkOutput("x211_round", root16, 15);
        checkOutput("x211_rem", rem16, 15);
        finishOp16();
        applyStimulus16(16'd225, 1'b1);
        checkOutput("x225_root", root16, 15);
        checkOutput("x225_rem", rem16, 0);
        checkOutput("x225_exact", ex16, 1'b1);
        finishOp16();

        applyStimulus16(16'd144, 1'b0);
        for (int i = 0; i < 20; i++) begin
            iv16 = 1'b1;
            checkOutput("hold_valid", ov16, 1'b1);
            checkOutput("hold_root", root16, 12);
            checkOutput("hold_rem", rem16, 0);
            checkOutput("hold_in_ready", ir16, 1'b0);
            @(negedge clk);
        end
        iv16 = 1'b0;
        finishOp16();
        applyStimulus16(16'd2, 1'b0);
        checkOutput("x2_root", root16, 1);
        checkOutput("x2_rem", rem16, 1);
        finishOp16();

        ordy16 = 1'b1;
        startOp16(16'd5000, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", ov16, 1'b0);
        checkOutput("midrst_in_ready", ir16, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("midrst_no_stale", ov16, 1'b0);
        end
        ordy16 = 1'b0;
        applyStimulus16(16'd10000, 1'b0);
        checkOutput("x10000_root", root16, 100);
        checkOutput("x10000_rem", rem16, 0);
        finishOp16();

        for (int i = 0; i < 40; i++) begin
            applyStimulus16(16'($urandom), 1'($urandom));
            finishOp16();
        end

        runOp32(32'd0, 1'b0);
        runOp32(32'd1, 1'b1);
        runOp32(32'hFFFF_FFFF, 1'b0);
        runOp32(32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            runOp32($urandom, 1'($urandom));
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
